// File: rtl/mem_if.sv
// Processor-to-memory request/acknowledge bus used by the memory phase.
// The master issues single-word requests; the slave completes each with a one-cycle ack.
`timescale 1ns/1ps
interface mem_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  logic          req;
  logic          wren;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          busy;

  modport master (
    output req, wren, address, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, wren, address, wdata,
    output rdata, ack, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM plus a display register at the top address,
// served through a req/ack handshake with WAIT programmable wait states.
`timescale 1ns/1ps
module mem_responder #(
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          n_rst,
  mem_if.slave          bus,
  output logic [DW-1:0] disp
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int            RAM_WORDS = (1 << AW) - 1;
  localparam logic [AW-1:0] DISP_ADDR = '1;
  localparam logic [3:0]    WAIT_LOAD = 4'((WAIT > 0) ? WAIT - 1 : 0);

  state_t        state, next_state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          wren_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic          start_resp;
  logic [AW-1:0] acc_addr;
  logic          acc_wren;
  logic [DW-1:0] acc_wdata;
  logic          acc_disp;
  logic          ram_we;

  logic [DW-1:0] mem [RAM_WORDS];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  // NOTE: defaulting next_state before the case keeps this purely combinational (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (bus.req) next_state = (WAIT == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == 4'd0) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are pure functions of the state.
  always_comb begin
    bus.ack  = (state == ST_RESP);
    bus.busy = (state != ST_IDLE);
  end

  // Request capture and wait-state counter; inputs are ignored once accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt     <= 4'd0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
    end else if (state == ST_IDLE && bus.req) begin
      cnt     <= WAIT_LOAD;
      addr_q  <= bus.address;
      wren_q  <= bus.wren;
      wdata_q <= bus.wdata;
    end else if (state == ST_WAIT) begin
      cnt     <= cnt - 4'd1;
    end
  end

  // With no wait states RESP is entered on the accepting edge, before the
  // capture registers hold the request, so the live inputs are used there.
  always_comb begin
    start_resp = (next_state == ST_RESP) && (state != ST_RESP);
    acc_addr   = (state == ST_IDLE) ? bus.address : addr_q;
    acc_wren   = (state == ST_IDLE) ? bus.wren    : wren_q;
    acc_wdata  = (state == ST_IDLE) ? bus.wdata   : wdata_q;
    acc_disp   = (acc_addr == DISP_ADDR);
    ram_we     = start_resp && acc_wren && !acc_disp && n_rst;
  end

  // NOTE: the RAM array has no reset; contents survive n_rst and map onto a block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) mem[acc_addr] <= acc_wdata;
  end

  // Read data and display register both update on the edge entering RESP.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rdata_q <= '0;
      disp    <= '0;
    end else if (start_resp) begin
      if (acc_wren) begin
        if (acc_disp) disp <= acc_wdata;
      end else begin
        rdata_q <= acc_disp ? disp : mem[acc_addr];
      end
    end
  end

  assign bus.rdata = rdata_q;

endmodule
